// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file and its scoreboard.
package cpu_pkg;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;
  localparam int RA_REG     = 15;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set when a writer issues, cleared on its write-back.
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issueValid,
  input  regAddr_t            issueRd,
  input  logic                clearValid,
  input  regAddr_t            clearRd,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] setVec;
  logic [NUM_REGS-1:0] clrVec;

  always_comb begin
    setVec = '0;
    clrVec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (issueValid && (issueRd == REG_ADDR_W'(i))) setVec[i] = 1'b1;
      if (clearValid && (clearRd == REG_ADDR_W'(i))) clrVec[i] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle re-issue keeps the register pending.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clrVec) | setVec;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Register file with write-back port, pending-write scoreboard and commit counter.
// Optional same-cycle write-to-read bypass is compiled in with RF_BYPASS_EN.
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  isWb,
  input  logic [REG_ADDR_W-1:0] writeRegAddr,
  input  logic [DATA_W-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] rs1Addr,
  input  logic [REG_ADDR_W-1:0] rs2Addr,
  output logic [DATA_W-1:0]     op1,
  output logic [DATA_W-1:0]     op2,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  output logic                  busy1,
  output logic                  busy2,
  output logic [31:0]           wbCount
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [31:0]         wbCountQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (isWb) begin
      regs[writeRegAddr] <= writeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     wbCountQ <= '0;
    else if (isWb) wbCountQ <= wbCountQ + 32'd1;
  end

  assign wbCount = wbCountQ;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) uScoreboard (
    .clk        (clk),
    .reset      (reset),
    .issueValid (issueValid),
    .issueRd    (issueRd),
    .clearValid (isWb),
    .clearRd    (writeRegAddr),
    .pending    (pending)
  );

`ifdef RF_BYPASS_EN
  logic hit1;
  logic hit2;

  // A same-cycle write-back to the read address forwards data and retires the hazard.
  always_comb begin
    hit1  = isWb && (writeRegAddr == rs1Addr);
    hit2  = isWb && (writeRegAddr == rs2Addr);
    op1   = hit1 ? writeData : regs[rs1Addr];
    op2   = hit2 ? writeData : regs[rs2Addr];
    busy1 = pending[rs1Addr] & ~hit1;
    busy2 = pending[rs2Addr] & ~hit2;
  end
`else
  always_comb begin
    op1   = regs[rs1Addr];
    op2   = regs[rs2Addr];
    busy1 = pending[rs1Addr];
    busy2 = pending[rs2Addr];
  end
`endif

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: array/scoreboard/counter model checked every cycle plus literal spot checks.
module tb_reg_file_wb;

  logic        clk;
  logic        reset;
  logic        isWb;
  logic [3:0]  writeRegAddr;
  logic [31:0] writeData;
  logic [3:0]  rs1Addr;
  logic [3:0]  rs2Addr;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        issueValid;
  logic [3:0]  issueRd;
  logic        busy1;
  logic        busy2;
  logic [31:0] wbCount;

  reg_file_wb dut (
    .clk          (clk),
    .reset        (reset),
    .isWb         (isWb),
    .writeRegAddr (writeRegAddr),
    .writeData    (writeData),
    .rs1Addr      (rs1Addr),
    .rs2Addr      (rs2Addr),
    .op1          (op1),
    .op2          (op2),
    .issueValid   (issueValid),
    .issueRd      (issueRd),
    .busy1        (busy1),
    .busy2        (busy2),
    .wbCount      (wbCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passCnt  = 0;
  int totalCnt = 0;
  bit chkEn    = 1'b0;

  logic [31:0] mRegs [16];
  bit          mPend [16];
  logic [31:0] mCnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  // Architectural model: registers, outstanding writers and commit count.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        mRegs[i] = 32'd0;
        mPend[i] = 1'b0;
      end
      mCnt = 32'd0;
    end else begin
      if (isWb) begin
        mRegs[writeRegAddr] = writeData;
        mPend[writeRegAddr] = 1'b0;
        mCnt = mCnt + 32'd1;
      end
      if (issueValid) mPend[issueRd] = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e1, e2;
    logic        b1, b2;
    if (chkEn) begin
      e1 = mRegs[rs1Addr];
      e2 = mRegs[rs2Addr];
      b1 = mPend[rs1Addr];
      b2 = mPend[rs2Addr];
`ifdef RF_BYPASS_EN
      if (isWb && writeRegAddr == rs1Addr) begin e1 = writeData; b1 = 1'b0; end
      if (isWb && writeRegAddr == rs2Addr) begin e2 = writeData; b2 = 1'b0; end
`endif
      chk("model_op1", op1, e1);
      chk("model_op2", op2, e2);
      chk("model_busy1", {31'd0, busy1}, {31'd0, b1});
      chk("model_busy2", {31'd0, busy2}, {31'd0, b2});
      chk("model_wbCount", wbCount, mCnt);
    end
  end

  task automatic cyc(input logic rst, input logic wb, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] r1, input logic [3:0] r2, input logic iv, input logic [3:0] ird);
    @(posedge clk);
    #2;
    reset = rst; isWb = wb; writeRegAddr = wa; writeData = wd;
    rs1Addr = r1; rs2Addr = r2; issueValid = iv; issueRd = ird;
    @(negedge clk);
  endtask

  task automatic idle(input logic [3:0] r1, input logic [3:0] r2);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, r1, r2, 1'b0, 4'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mRegs[i] = 32'd0;
      mPend[i] = 1'b0;
    end
    mCnt = 32'd0;
    reset = 1'b1; isWb = 1'b0; writeRegAddr = '0; writeData = '0;
    rs1Addr = '0; rs2Addr = '0; issueValid = 1'b0; issueRd = '0;

    cyc(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b0, 4'd0);
    chkEn = 1'b1;

    // Post-reset: everything reads zero
    idle(4'd6, 4'd11);
    chk("rst_op1", op1, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_wbCount", wbCount, 32'd0);

    // Write r3, read it back next cycle
    cyc(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 4'd3, 4'd0, 1'b0, 4'd0);
    idle(4'd3, 4'd0);
    chk("wr3_op1", op1, 32'hDEADBEEF);
    chk("wr3_wbCount", wbCount, 32'd1);

    // Call: issue r15, then its write-back of the return address
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd15, 1'b1, 4'd15);
    idle(4'd0, 4'd15);
    chk("call_busy2", {31'd0, busy2}, 32'd1);
    cyc(1'b0, 1'b1, 4'd15, 32'h00000104, 4'd0, 4'd15, 1'b0, 4'd0);
    idle(4'd0, 4'd15);
    chk("ret_busy2", {31'd0, busy2}, 32'd0);
    chk("ret_op2", op2, 32'h00000104);
    chk("ret_wbCount", wbCount, 32'd2);

    // Same-cycle issue and write-back on a pending r5: stays pending
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 4'd5, 4'd0, 1'b1, 4'd5);
    cyc(1'b0, 1'b1, 4'd5, 32'h00000055, 4'd5, 4'd0, 1'b1, 4'd5);
    idle(4'd5, 4'd5);
    chk("reissue_busy1", {31'd0, busy1}, 32'd1);
    chk("reissue_op1", op1, 32'h00000055);

    // Clearing a non-pending register leaves r5 pending
    cyc(1'b0, 1'b1, 4'd9, 32'h99990009, 4'd5, 4'd9, 1'b0, 4'd0);
    idle(4'd5, 4'd9);
    chk("clr_np_busy1", {31'd0, busy1}, 32'd1);
    chk("clr_np_busy2", {31'd0, busy2}, 32'd0);
    chk("clr_np_op2", op2, 32'h99990009);

    // Read and write r7 in the same cycle
    cyc(1'b0, 1'b1, 4'd7, 32'hAAAA0000, 4'd0, 4'd0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 4'd7, 32'h12345678, 4'd7, 4'd0, 1'b0, 4'd0);
`ifdef RF_BYPASS_EN
    chk("rw7_same_op1", op1, 32'h12345678);
`else
    chk("rw7_same_op1", op1, 32'hAAAA0000);
`endif
    idle(4'd7, 4'd7);
    chk("rw7_next_op1", op1, 32'h12345678);

    // r0 is an ordinary register
    cyc(1'b0, 1'b1, 4'd0, 32'h00001111, 4'd0, 4'd0, 1'b0, 4'd0);
    idle(4'd0, 4'd3);
    chk("r0_op1", op1, 32'h00001111);
    chk("r0_op2_r3", op2, 32'hDEADBEEF);

    // Fill all registers with issues interleaved; model tracks every cycle
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 4'(i), 32'hC0DE0000 + 32'(i * 17), 4'(15 - i), 4'(i), 1'b1, 4'((i + 3) % 16));
    end
    idle(4'd10, 4'd4);
    chk("fill_op1_r10", op1, 32'hC0DE0000 + 32'd170);
    chk("fill_op2_r4", op2, 32'hC0DE0000 + 32'd68);

    // Counter wrap: preload to all-ones, then one more write-back
    @(posedge clk);
    #2;
    force dut.wbCountQ = 32'hFFFFFFFF;
    mCnt = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.wbCountQ;
    chk("wrap_preload", wbCount, 32'hFFFFFFFF);
    cyc(1'b0, 1'b1, 4'd12, 32'h0000000C, 4'd0, 4'd0, 1'b0, 4'd0);
    idle(4'd12, 4'd0);
    chk("wrap_wbCount", wbCount, 32'd0);

    // Reset beats a same-cycle write-back and issue to r2
    cyc(1'b0, 1'b1, 4'd2, 32'h22222222, 4'd2, 4'd0, 1'b1, 4'd2);
    cyc(1'b1, 1'b1, 4'd2, 32'h33333333, 4'd2, 4'd0, 1'b1, 4'd2);
    idle(4'd2, 4'd13);
    chk("rstpri_op1", op1, 32'd0);
    chk("rstpri_busy1", {31'd0, busy1}, 32'd0);
    chk("rstpri_wbCount", wbCount, 32'd0);
    chk("rstpri_op2", op2, 32'd0);

    idle(4'd0, 4'd0);
    chkEn = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
